// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 rate-block packer.
package sha3_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    PAD   = 3'd3,
    SEND  = 3'd4,
    DONE  = 3'd5
  } sha3_state_e;

  localparam logic [31:0] SHA3_DOMAIN_PAD = 32'h00000006;
  localparam logic [31:0] SHA3_LAST_PAD   = 32'h80000000;

  localparam int RATE224 = 36;
  localparam int RATE256 = 34;
  localparam int RATE384 = 26;
  localparam int RATE512 = 18;

  // Pad bits OR-ed into one buffer word: domain byte at the first free word,
  // closing bit at the top of the last rate word (both may hit the same word).
  function automatic logic [31:0] sha3_pad_word(input logic is_first_free,
                                                input logic is_last_word);
    sha3_pad_word = (is_first_free ? SHA3_DOMAIN_PAD : 32'h0) |
                    (is_last_word  ? SHA3_LAST_PAD   : 32'h0);
  endfunction

endpackage

// File: rtl/sha3_blk_buf.sv
// Rate-block buffer: indexed word write, OR-merge of pad10*1 bits, and clear.
module sha3_blk_buf
  import sha3_pkg::*;
#(
  parameter int RATEW = RATE256,
  parameter int WID   = 32,
  parameter int IDXB  = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   wr_en_i,
  input  logic                   pad_en_i,
  input  logic [IDXB-1:0]        idx_i,
  input  logic [WID-1:0]         wr_data_i,
  output logic [RATEW*WID-1:0]   data_o
);

  logic [WID-1:0] word_q [RATEW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RATEW; i++) word_q[i] <= '0;
    end else begin
      for (int i = 0; i < RATEW; i++) begin
        if (clr_i) begin
          word_q[i] <= '0;
        end else if (wr_en_i && (idx_i == IDXB'(i))) begin
          word_q[i] <= wr_data_i;
        end else if (pad_en_i) begin
          word_q[i] <= word_q[i] | sha3_pad_word(idx_i == IDXB'(i), i == RATEW - 1);
        end
      end
    end
  end

  for (genvar g = 0; g < RATEW; g++) begin : g_flat
    assign data_o[g*WID +: WID] = word_q[g];
  end

endmodule

// File: rtl/sha3_blk_pack.sv
// Drains 32-bit words from the read side of the word FIFO, packs them into
// SHA-3 rate blocks with pad10*1 (domain 0x06) and offers them to the absorb core.
module sha3_blk_pack
  import sha3_pkg::*;
#(
  parameter int RATEW = RATE256,
  parameter int WID   = 32,
  parameter int LENB  = 16,
  parameter int IDXB  = 6
) (
  input  logic                 rdclk,
  input  logic                 rdrst,
  input  logic                 start,
  input  logic [LENB-1:0]      msgwords,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  input  logic                 fifordy,
  output logic                 fifoget,
  input  logic                 fifovld,
  input  logic [WID-1:0]       fifodout,
  output logic                 blkvld,
  input  logic                 blkrdy,
  output logic [RATEW*WID-1:0] blkdata,
  output logic                 blklast,
  output logic                 perr,
  output sha3_state_e          dbg_state_o
);

  // Block handshake: blkvld rises independently of blkrdy; blkdata and blklast
  // hold steady while blkvld is high, and the block transfers on the first
  // rising rdclk edge that sees blkvld & blkrdy.
  localparam logic [IDXB-1:0] RATE_IDX = IDXB'(RATEW);

  sha3_state_e     state_q, state_d;
  logic [LENB-1:0] rem_q, rem_d;
  logic [IDXB-1:0] widx_q, widx_d, widx_inc;
  logic [LENB-1:0] rem_dec;
  logic            padpend_q, padpend_d;
  logic            outst_q, outst_d;
  logic            discard_q, discard_d;
  logic            perr_q, perr_d;
  logic            last_q, last_d;
  logic            buf_clr, buf_wr, buf_pad;

  always_ff @(posedge rdclk or posedge rdrst) begin
    if (rdrst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      widx_q    <= '0;
      padpend_q <= 1'b0;
      outst_q   <= 1'b0;
      discard_q <= 1'b0;
      perr_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      widx_q    <= widx_d;
      padpend_q <= padpend_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      perr_q    <= perr_d;
      last_q    <= last_d;
    end
  end

  assign widx_inc = widx_q + 1'b1;
  assign rem_dec  = rem_q - 1'b1;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    widx_d    = widx_q;
    padpend_d = padpend_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    perr_d    = perr_q;
    last_d    = last_q;
    buf_clr   = 1'b0;
    buf_wr    = 1'b0;
    buf_pad   = 1'b0;
    fifoget   = 1'b0;

    // A response with no get in flight is either the tail of an aborted read or an error.
    if (fifovld && !outst_q) begin
      if (discard_q) discard_d = 1'b0;
      else           perr_d    = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d     = msgwords;
          widx_d    = '0;
          padpend_d = 1'b0;
          last_d    = 1'b0;
          buf_clr   = 1'b1;
          state_d   = (msgwords == '0) ? PAD : FETCH;
        end
      end
      FETCH: begin
        if (fifordy && !discard_q && (rem_q != '0) && (widx_q != RATE_IDX)) begin
          fifoget = 1'b1;
          outst_d = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (fifovld && outst_q) begin
          buf_wr  = 1'b1;
          widx_d  = widx_inc;
          rem_d   = rem_dec;
          outst_d = 1'b0;
          if (rem_dec == '0 && widx_inc != RATE_IDX) begin
            state_d = PAD;
          end else if (rem_dec == '0) begin
            padpend_d = 1'b1;
            last_d    = 1'b0;
            state_d   = SEND;
          end else if (widx_inc == RATE_IDX) begin
            state_d = SEND;
          end else begin
            state_d = FETCH;
          end
        end
      end
      PAD: begin
        buf_pad = 1'b1;
        last_d  = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (blkrdy) begin
          buf_clr = 1'b1;
          widx_d  = '0;
          if (last_q) begin
            state_d = DONE;
          end else if (padpend_q) begin
            padpend_d = 1'b0;
            state_d   = PAD;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d   = IDLE;
      rem_d     = '0;
      widx_d    = '0;
      padpend_d = 1'b0;
      last_d    = 1'b0;
      outst_d   = 1'b0;
      discard_d = discard_q | (outst_q & ~fifovld);
      buf_clr   = 1'b1;
      buf_wr    = 1'b0;
      buf_pad   = 1'b0;
      fifoget   = 1'b0;
    end
  end

  sha3_blk_buf #(
    .RATEW (RATEW),
    .WID   (WID),
    .IDXB  (IDXB)
  ) u_buf (
    .clk_i     (rdclk),
    .rst_i     (rdrst),
    .clr_i     (buf_clr),
    .wr_en_i   (buf_wr),
    .pad_en_i  (buf_pad),
    .idx_i     (widx_q),
    .wr_data_i (fifodout),
    .data_o    (blkdata)
  );

  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);
  assign blkvld      = (state_q == SEND);
  assign blklast     = blkvld & last_q;
  assign perr        = perr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sha3_blk_pack.sv
// Directed bench for sha3_blk_pack with a latency-programmable FIFO read responder.
module tb_sha3_blk_pack;
  import sha3_pkg::*;

  localparam int RATEW = 34;
  localparam int WID   = 32;
  localparam int LENB  = 16;
  localparam int IDXB  = 6;

  logic                 rdclk = 1'b0;
  logic                 rdrst = 1'b1;
  logic                 start = 1'b0;
  logic [LENB-1:0]      msgwords = '0;
  logic                 abort = 1'b0;
  logic                 fifordy = 1'b0;
  logic                 blkrdy = 1'b0;
  logic                 resp_vld = 1'b0;
  logic                 inj_vld = 1'b0;
  logic                 fifovld;
  logic [WID-1:0]       fifodout = '0;
  logic                 busy, done, fifoget, blkvld, blklast, perr;
  logic [RATEW*WID-1:0] blkdata;
  sha3_state_e          dbg_state;

  int checks = 0;
  int errors = 0;
  int gets = 0;
  int fifo_lat = 1;
  bit resp_drop = 1'b0;

  logic [WID-1:0] src_q[$];
  logic [WID-1:0] exp_q[$];
  logic [WID-1:0] got_w[RATEW];
  logic           got_last;
  logic [WID-1:0] exp_w;

  assign fifovld = resp_vld | inj_vld;

  sha3_blk_pack #(.RATEW(RATEW), .WID(WID), .LENB(LENB), .IDXB(IDXB)) dut (
    .rdclk(rdclk), .rdrst(rdrst), .start(start), .msgwords(msgwords), .abort(abort),
    .busy(busy), .done(done), .fifordy(fifordy), .fifoget(fifoget), .fifovld(fifovld),
    .fifodout(fifodout), .blkvld(blkvld), .blkrdy(blkrdy), .blkdata(blkdata),
    .blklast(blklast), .perr(perr), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 rdclk = ~rdclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- FIFO read responder ----------------
  always begin
    @(negedge rdclk);
    if (fifoget === 1'b1) begin
      gets++;
      @(posedge rdclk);
      repeat (fifo_lat - 1) @(posedge rdclk);
      #1;
      if (!resp_drop) begin
        resp_vld = 1'b1;
        fifodout = (src_q.size() > 0) ? src_q.pop_front() : '0;
        @(posedge rdclk);
        #1 resp_vld = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int n);
    @(posedge rdclk);
    #1 msgwords = LENB'(n);
    start = 1'b1;
    @(posedge rdclk);
    #1 start = 1'b0;
  endtask

  task automatic wait_blk(input int maxc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge rdclk);
      if (blkvld === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    for (int i = 0; i < RATEW; i++) got_w[i] = blkdata[i*WID +: WID];
    got_last = blklast;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge rdclk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Expected word i of a final block holding n (< RATEW) data words base+k.
  function automatic logic [WID-1:0] pad_exp(input int i, input int n, input logic [WID-1:0] base);
    logic [WID-1:0] w;
    w = (i < n) ? base + WID'(i) : '0;
    if (i == n) w = w | 32'h00000006;
    if (i == RATEW - 1) w = w | 32'h80000000;
    return w;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    rdrst = 1'b1;
    @(negedge rdclk);
    checks++;
    if ({busy, done, fifoget, blkvld, blklast, perr} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=000000", {busy, done, fifoget, blkvld, blklast, perr});
    end
    checks++;
    if (blkdata !== '0) begin
      errors++;
      $display("FAIL reset_blkdata got_w0=%h exp=0", blkdata[31:0]);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
    end
    @(posedge rdclk);
    #1 rdrst = 1'b0;
    fifordy = 1'b1;
    blkrdy = 1'b1;
  endtask

  task automatic test_one_word;
    bit ok;
    gets = 0;
    src_q = '{32'hDEADBEEF};
    do_start(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got=%b exp=1", busy); end
    wait_blk(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t1_blk_timeout got=0 exp=1"); end
    exp_q = {};
    for (int i = 0; i < RATEW; i++) exp_q.push_back(pad_exp(i, 1, 32'hDEADBEEF));
    for (int i = 0; i < RATEW; i++) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (got_w[i] !== exp_w) begin errors++; $display("FAIL t1_word%0d got=%h exp=%h", i, got_w[i], exp_w); end
    end
    checks++;
    if (got_last !== 1'b1) begin errors++; $display("FAIL t1_blklast got=%b exp=1", got_last); end
    wait_done(5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t1_done got=0 exp=1"); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_at_done got=%b exp=0", busy); end
    @(negedge rdclk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse got=%b exp=0", done); end
    repeat (3) @(negedge rdclk);
    checks++;
    if (gets !== 1) begin errors++; $display("FAIL t1_gets got=%0d exp=1", gets); end
  endtask

  task automatic test_empty;
    bit ok;
    gets = 0;
    do_start(0);
    wait_blk(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t2_blk_timeout got=0 exp=1"); end
    for (int i = 0; i < RATEW; i++) begin
      exp_w = pad_exp(i, 0, '0);
      checks++;
      if (got_w[i] !== exp_w) begin errors++; $display("FAIL t2_word%0d got=%h exp=%h", i, got_w[i], exp_w); end
    end
    checks++;
    if (got_last !== 1'b1) begin errors++; $display("FAIL t2_blklast got=%b exp=1", got_last); end
    wait_done(5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t2_done got=0 exp=1"); end
    checks++;
    if (gets !== 0) begin errors++; $display("FAIL t2_gets got=%0d exp=0", gets); end
  endtask

  task automatic test_rate_minus_one;
    bit ok;
    gets = 0;
    fifo_lat = 3;
    src_q = {};
    for (int i = 0; i < 33; i++) src_q.push_back(WID'(i));
    do_start(33);
    wait_blk(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t3_blk_timeout got=0 exp=1"); end
    for (int i = 0; i < RATEW; i++) begin
      exp_w = pad_exp(i, 33, '0);
      checks++;
      if (got_w[i] !== exp_w) begin errors++; $display("FAIL t3_word%0d got=%h exp=%h", i, got_w[i], exp_w); end
    end
    checks++;
    if (got_last !== 1'b1) begin errors++; $display("FAIL t3_blklast got=%b exp=1", got_last); end
    wait_done(5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t3_done got=0 exp=1"); end
    checks++;
    if (gets !== 33) begin errors++; $display("FAIL t3_gets got=%0d exp=33", gets); end
    fifo_lat = 1;
  endtask

  task automatic test_full_rate;
    bit ok;
    gets = 0;
    src_q = {};
    for (int i = 0; i < 34; i++) src_q.push_back(32'h1000 + WID'(i));
    do_start(34);
    wait_blk(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t4_blk1_timeout got=0 exp=1"); end
    for (int i = 0; i < RATEW; i++) begin
      exp_w = 32'h1000 + WID'(i);
      checks++;
      if (got_w[i] !== exp_w) begin errors++; $display("FAIL t4_b1_word%0d got=%h exp=%h", i, got_w[i], exp_w); end
    end
    checks++;
    if (got_last !== 1'b0) begin errors++; $display("FAIL t4_b1_blklast got=%b exp=0", got_last); end
    @(posedge rdclk);
    wait_blk(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t4_blk2_timeout got=0 exp=1"); end
    for (int i = 0; i < RATEW; i++) begin
      exp_w = pad_exp(i, 0, '0);
      checks++;
      if (got_w[i] !== exp_w) begin errors++; $display("FAIL t4_b2_word%0d got=%h exp=%h", i, got_w[i], exp_w); end
    end
    checks++;
    if (got_last !== 1'b1) begin errors++; $display("FAIL t4_b2_blklast got=%b exp=1", got_last); end
    wait_done(5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t4_done got=0 exp=1"); end
    checks++;
    if (gets !== 34) begin errors++; $display("FAIL t4_gets got=%0d exp=34", gets); end
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [WID-1:0] held [RATEW];
    gets = 0;
    blkrdy = 1'b0;
    src_q = {};
    for (int i = 0; i < 35; i++) src_q.push_back(32'hA000 + WID'(i));
    do_start(35);
    wait_blk(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t5_blk1_timeout got=0 exp=1"); end
    for (int i = 0; i < RATEW; i++) held[i] = got_w[i];
    checks++;
    if (got_last !== 1'b0) begin errors++; $display("FAIL t5_b1_blklast got=%b exp=0", got_last); end
    for (int k = 0; k < 10; k++) begin
      @(negedge rdclk);
      checks++;
      if (blkvld !== 1'b1) begin errors++; $display("FAIL t5_hold_vld cycle%0d got=%b exp=1", k, blkvld); end
      for (int i = 0; i < RATEW; i++) begin
        if (blkdata[i*WID +: WID] !== held[i]) begin
          checks++;
          errors++;
          $display("FAIL t5_hold_data cycle%0d word%0d got=%h exp=%h", k, i, blkdata[i*WID +: WID], held[i]);
          break;
        end
      end
    end
    checks++;
    if (gets !== 34) begin errors++; $display("FAIL t5_gets_in_send got=%0d exp=34", gets); end
    @(posedge rdclk);
    #1 blkrdy = 1'b1;
    @(posedge rdclk);
    wait_blk(30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t5_blk2_timeout got=0 exp=1"); end
    for (int i = 0; i < RATEW; i++) begin
      exp_w = pad_exp(i, 1, 32'hA000 + 32'd34);
      checks++;
      if (got_w[i] !== exp_w) begin errors++; $display("FAIL t5_b2_word%0d got=%h exp=%h", i, got_w[i], exp_w); end
    end
    checks++;
    if (got_last !== 1'b1) begin errors++; $display("FAIL t5_b2_blklast got=%b exp=1", got_last); end
    wait_done(5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t5_done got=0 exp=1"); end
    checks++;
    if (gets !== 35) begin errors++; $display("FAIL t5_gets got=%0d exp=35", gets); end
  endtask

  task automatic test_perr;
    @(posedge rdclk);
    #1 inj_vld = 1'b1;
    @(posedge rdclk);
    #1 inj_vld = 1'b0;
    @(negedge rdclk);
    checks++;
    if (perr !== 1'b1) begin errors++; $display("FAIL t6_perr_set got=%b exp=1", perr); end
    repeat (5) @(negedge rdclk);
    checks++;
    if (perr !== 1'b1) begin errors++; $display("FAIL t6_perr_sticky got=%b exp=1", perr); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL t6_perr_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_wait;
    bit ok;
    gets = 0;
    resp_drop = 1'b1;
    fifo_lat = 4;
    do_start(3);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge rdclk);
      if (gets == 1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL t6_get_timeout got=0 exp=1"); end
    @(posedge rdclk);
    #1;
    checks++;
    if (dbg_state !== WAIT) begin errors++; $display("FAIL t6_in_wait got=%0d exp=%0d", dbg_state, WAIT); end
    rdrst = 1'b1;
    #1;
    checks++;
    if ({busy, done, fifoget, blkvld, blklast, perr} !== 6'b0) begin
      errors++;
      $display("FAIL t6_rst_outputs got=%b exp=000000", {busy, done, fifoget, blkvld, blklast, perr});
    end
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL t6_rst_state got=%0d exp=%0d", dbg_state, IDLE); end
    repeat (6) @(posedge rdclk);
    #1 rdrst = 1'b0;
    resp_drop = 1'b0;
    fifo_lat = 2;
    gets = 0;
    src_q = '{32'h12345678};
    do_start(1);
    wait_blk(30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t6_blk_timeout got=0 exp=1"); end
    for (int i = 0; i < RATEW; i++) begin
      exp_w = pad_exp(i, 1, 32'h12345678);
      checks++;
      if (got_w[i] !== exp_w) begin errors++; $display("FAIL t6_word%0d got=%h exp=%h", i, got_w[i], exp_w); end
    end
    wait_done(5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t6_done got=0 exp=1"); end
    checks++;
    if (gets !== 1 || perr !== 1'b0) begin
      errors++;
      $display("FAIL t6_after_reset gets=%0d perr=%b exp gets=1 perr=0", gets, perr);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_one_word();
    test_empty();
    test_rate_minus_one();
    test_full_rate();
    test_backpressure();
    test_perr();
    test_reset_mid_wait();
    repeat (3) @(posedge rdclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha3_blk_pack.md
Name: sha3_blk_pack

Overview:
Read-side consumer for the ready-handshake dual-clock word FIFO. It drains 32-bit message words with the fifordy/fifoget/fifovld protocol and packs them little-endian into Keccak rate blocks. It applies SHA-3 pad10*1 with domain byte 0x06 at word granularity and hands complete blocks to the Keccak absorb core through a valid/ready interface. It sits in the rdclk domain, between the FIFO read port and the permutation core.

Parameters:
RATEW, 34, words per rate block (34 = SHA3-256, 1088 bits); legal 18..42
WID, 32, FIFO word width; fixed at 32
LENB, 16, width of message word count
IDXB, 6, width of word index; must satisfy 2**IDXB > RATEW

Ports:
rdclk  in  1  clock (FIFO read clock)
rdrst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; latches msgwords; ignored unless idle
msgwords  in  LENB  message length in 32-bit words
abort  in  1  return to idle, discard partial block
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the final block handshake
fifordy  in  1  FIFO holds at least one word
fifoget  out  1  one-cycle read request
fifovld  in  1  read data valid, 1..4 cycles after fifoget
fifodout  in  WID  read data
blkvld  out  1  block valid
blkrdy  in  1  core accepts block
blkdata  out  RATEW*WID  word i sits at bits [32i+31:32i]
blklast  out  1  qualifies blkvld; final (padded) block
perr  out  1  sticky: fifovld with no outstanding get

Behaviour:
- Reset: every output is 0, blkdata is 0, state is IDLE, counters are 0. Reset is asynchronous and active-high on rdrst.
- Registers: rem (LENB), widx (IDXB), block buffer RATEW x 32, padpend, one outstanding-get flag.
- IDLE:
  - On start, rem = msgwords, widx = 0, buffer cleared, busy = 1.
  - If msgwords == 0, go to PAD; otherwise go to FETCH.
- FETCH:
  - If fifordy is high, assert fifoget for exactly one cycle, set the outstanding flag, and go to WAIT.
  - At most one get is outstanding at any time.
- WAIT:
  - On fifovld, write fifodout to buffer[widx], increment widx, decrement rem, clear the outstanding flag.
  - If rem becomes 0 and widx < RATEW, go to PAD.
  - If rem becomes 0 and widx == RATEW, set padpend and go to SEND with blklast = 0.
  - If rem != 0 and widx == RATEW, go to SEND.
  - Otherwise go to FETCH.
- PAD (one cycle):
  - buffer[widx] |= 32'h00000006.
  - buffer[RATEW-1] |= 32'h80000000. When widx == RATEW-1 the same word becomes 32'h80000006.
  - All other remaining words are 0. Go to SEND with blklast = 1.
- SEND:
  - blkvld is held and blkdata/blklast are stable until blkvld & blkrdy.
  - On the handshake the buffer clears and widx = 0. Then:
    - if blklast was set, go to DONE;
    - else if padpend is set, clear padpend and go to PAD (all-pad block);
    - else go to FETCH.
  - blkvld may be asserted in the same cycle as any blkrdy value.
- DONE: pulse done for one cycle, drop busy, go to IDLE.
- Throughput is one word per (1 + FIFO read latency) cycles. Block output adds 1 cycle for PAD, plus backpressure.
- Flow control:
  - fifoget is never issued when rem == 0 or when widx == RATEW.
  - No more than msgwords words are consumed per message.
- perr:
  - Set when fifovld arrives while the outstanding flag is clear. The word is dropped and perr stays set until reset.
- abort:
  - Takes effect next cycle from any state: go to IDLE, blkvld = 0, busy = 0, no done pulse.
  - If a get is outstanding, hold a discard flag and swallow the next fifovld without raising perr.
- start while busy is ignored.

Decomposition:
- Package sha3_pkg holds:
  - the state enum (IDLE, FETCH, WAIT, PAD, SEND, DONE);
  - SHA3_DOMAIN_PAD = 32'h00000006 and SHA3_LAST_PAD = 32'h80000000;
  - the rate constants RATE224 = 36, RATE256 = 34, RATE384 = 26, RATE512 = 18.
- Optional sub-module sha3_blk_buf: the RATEW-word buffer with indexed write, OR-merge pad and clear.

Test Plan:
1. msgwords = 1, FIFO returns 32'hDEADBEEF -> one block: w0 = DEADBEEF, w1 = 00000006, w2..w32 = 0, w33 = 80000000, blklast = 1, then done pulse; exactly one fifoget.
2. msgwords = 0 -> no fifoget; one block with w0 = 00000006, w33 = 80000000, blklast = 1.
3. msgwords = 33, data = index values 0..32 -> w32 = 32, w33 = 80000006, single block, blklast = 1.
4. msgwords = 34 -> block 1 carries the 34 data words with blklast = 0; block 2 is all-pad (w0 = 06, w33 = 80000000) with blklast = 1; 34 gets total.
5. Hold blkrdy low 10 cycles with fifordy high -> blkvld and blkdata stable, no fifoget during SEND; release -> handshake and fetching resumes.
6. Inject fifovld while idle -> perr = 1 and sticky. Separately, assert rdrst mid-WAIT -> all outputs 0 immediately, and the next start of 1 word works normally.
